mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, max cycles a transaction may spend in REQ+RESP before abort; legal range 2..255.
REQ-002 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-low.
REQ-004 if_req_i  in  1  fetch requester wants a read.
REQ-005 if_addr_i  in  32  fetch word address.
REQ-006 if_gnt_o  out  1  fetch request captured this cycle.
REQ-007 if_rvalid_o  out  1  fetch response valid, one-cycle pulse.
REQ-008 if_rdata_o  out  32  fetch read data.
REQ-009 if_err_o  out  1  fetch response is a timeout error; qualified by if_rvalid_o.
REQ-010 ls_req_i  in  1  load/store requester wants an access.
REQ-011 ls_we_i  in  1  1 = write, 0 = read.
REQ-012 ls_be_i  in  4  byte enables.
REQ-013 ls_addr_i  in  32  load/store address.
REQ-014 ls_wdata_i  in  32  write data.
REQ-015 ls_lock_i  in  1  hold the memory port for the next load/store access (AMO sequences).
REQ-016 ls_gnt_o, ls_rvalid_o, ls_err_o  out  1 each; ls_rdata_o  out  32; same meaning as the fetch equivalents.
REQ-017 mem_req_o  out  1; mem_we_o  out  1; mem_be_o  out  4; mem_addr_o  out  32; mem_wdata_o  out  32: shared memory port request.
REQ-018 mem_gnt_i  in  1  memory accepted request; mem_rvalid_i  in  1  response (read data or write ack); mem_rdata_i  in  32.

Function
REQ-019 FSM states IDLE, REQ, RESP; exactly one outstanding transaction.
REQ-020 IDLE: if any request present, winner's gnt_o = 1 combinationally, request fields latched at edge, FSM -> REQ; else stay IDLE, both gnt_o = 0.
REQ-021 Arbitration: one requester only -> that one; both -> requester indicated by priority bit; priority bit flips to the non-winner on every completion (round robin).
REQ-022 Fetch requests latched with we = 0, be = 4'b1111, wdata = 0.
REQ-023 REQ: mem_req_o = 1 driven from latched registers, held stable until mem_gnt_i = 1; then -> RESP.
REQ-024 RESP: mem_req_o = 0; on mem_rvalid_i = 1 owner's rvalid_o = 1 and rdata_o = mem_rdata_i same cycle (combinational forward), err_o = 0, FSM -> IDLE.
REQ-025 mem_rvalid_i outside RESP ignored; rdata_o = 0 whenever rvalid_o = 0.
REQ-026 Minimum latency: gnt in cycle N, mem_gnt_i in N+1, rvalid_o in N+2.
REQ-027 Lock: if ls_lock_i = 1 when the load/store request is granted, lock flag set at that grant; while set, IDLE grants only load/store (fetch waits), priority bit not updated; flag cleared when a load/store granted with ls_lock_i = 0 completes.
REQ-028 Timeout: 8-bit counter cleared on entry to REQ, increments each cycle in REQ/RESP; reaching TIMEOUT_CYCLES -> owner's rvalid_o = 1, err_o = 1, rdata_o = 0, mem_req_o deasserted, FSM -> IDLE, lock flag cleared.
REQ-029 Timeout and mem_rvalid_i in the same cycle: normal response wins, err_o = 0.
REQ-030 Requester deasserting req_i after grant has no effect on the captured transaction.

Reset
REQ-031 On rst_i = 0, immediately: FSM = IDLE, priority bit = fetch, lock flag = 0, counter = 0, all outputs 0, including mid-transaction; a pending memory response after release is ignored.
REQ-032 First arbitration evaluated on the first rising edge with rst_i = 1.

Verification
REQ-033 Fetch only, addr 0x0000_0100, mem_gnt_i and mem_rvalid_i immediate, rdata 0x0000_0013 -> if_gnt_o cycle N, mem_addr_o 0x100 cycle N+1, if_rvalid_o with 0x13 cycle N+2.
REQ-034 Both request continuously after reset -> grants alternate fetch, LSU, fetch, LSU.
REQ-035 LSU lock: read 0x2000 with ls_lock_i = 1, then write 0x2000 data 0xDEAD_BEEF lock = 0, fetch pending throughout -> fetch granted only after write completes.
REQ-036 TIMEOUT_CYCLES = 8, mem_gnt_i held 0 -> ls_rvalid_o = 1, ls_err_o = 1, ls_rdata_o = 0 eight cycles after entry to REQ; next request served normally.
REQ-037 rst_i = 0 asserted while in RESP -> outputs 0 without waiting for clock; after release stale mem_rvalid_i produces no rvalid_o.
REQ-038 LSU write, be 4'b0011, wdata 0x0000_1234, addr 0x3004 -> mem_we_o = 1 with these values on the port; ls_rvalid_o pulses on write ack.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester (fetch, load/store) arbiter for one shared memory port.
// One outstanding transaction, round-robin with LSU lock and a timeout abort.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [3:0]  ls_be_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  input  logic        ls_lock_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  output logic        ls_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);
  // state  | meaning
  // S_IDLE | no transaction; arbitrate and capture the winner
  // S_REQ  | request on memory port, waiting for mem_gnt_i
  // S_RESP | accepted, waiting for mem_rvalid_i
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RESP = 2'd2} state_t;

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT_CYCLES);

  state_t      r_state;
  logic        r_prio;     // 0 = fetch preferred, 1 = load/store preferred
  logic        r_lock;
  logic        r_owner;    // 0 = fetch, 1 = load/store
  logic        r_cur_lock;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [7:0]  r_cnt;

  logic w_idle, w_if_win, w_ls_win, w_grant;
  logic w_timeout, w_resp_ok, w_done, w_lock_keep, w_in_req;

  assign w_idle    = (r_state == S_IDLE);
  assign w_if_win  = w_idle & if_req_i & ~r_lock & (~ls_req_i | ~r_prio);
  assign w_ls_win  = w_idle & ls_req_i & ~w_if_win;
  assign w_grant   = w_if_win | w_ls_win;

  // A real response in the same cycle as the timeout takes precedence.
  assign w_resp_ok   = (r_state == S_RESP) & mem_rvalid_i;
  assign w_timeout   = ~w_idle & (r_cnt == LP_TIMEOUT);
  assign w_done      = w_resp_ok | w_timeout;
  assign w_lock_keep = r_lock & w_resp_ok & ~(r_owner & ~r_cur_lock);
  assign w_in_req    = (r_state == S_REQ) & ~w_timeout;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_prio     <= 1'b0;
      r_lock     <= 1'b0;
      r_owner    <= 1'b0;
      r_cur_lock <= 1'b0;
      r_we       <= 1'b0;
      r_be       <= 4'h0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state <= S_REQ;
            r_cnt   <= '0;
            r_owner <= w_ls_win;
            if (w_ls_win) begin
              r_we       <= ls_we_i;
              r_be       <= ls_be_i;
              r_addr     <= ls_addr_i;
              r_wdata    <= ls_wdata_i;
              r_cur_lock <= ls_lock_i;
              if (ls_lock_i) r_lock <= 1'b1;
            end else begin
              r_we       <= 1'b0;
              r_be       <= 4'hF;
              r_addr     <= if_addr_i;
              r_wdata    <= '0;
              r_cur_lock <= 1'b0;
            end
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 8'd1;
          if (mem_gnt_i) r_state <= S_RESP;
        end
        S_RESP:  r_cnt <= r_cnt + 8'd1;
        default: r_state <= S_IDLE;
      endcase
      if (w_done) begin
        r_state <= S_IDLE;
        r_lock  <= w_lock_keep;
        if (!w_lock_keep) r_prio <= ~r_owner;
      end
    end
  end

  // Grants are combinational from the request lines, so gate them during reset.
  assign if_gnt_o    = rst_i & w_if_win;
  assign ls_gnt_o    = rst_i & w_ls_win;

  assign mem_req_o   = w_in_req;
  assign mem_we_o    = w_in_req & r_we;
  assign mem_be_o    = w_in_req ? r_be    : 4'h0;
  assign mem_addr_o  = w_in_req ? r_addr  : 32'h0;
  assign mem_wdata_o = w_in_req ? r_wdata : 32'h0;

  assign if_rvalid_o = w_done & ~r_owner;
  assign ls_rvalid_o = w_done & r_owner;
  assign if_err_o    = if_rvalid_o & ~w_resp_ok;
  assign ls_err_o    = ls_rvalid_o & ~w_resp_ok;
  assign if_rdata_o  = (if_rvalid_o & w_resp_ok) ? mem_rdata_i : 32'h0;
  assign ls_rdata_o  = (ls_rvalid_o & w_resp_ok) ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, round robin, lock, timeout, reset.
module tb_mem_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_rvalid_o, if_err_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i, ls_we_i, ls_lock_i;
  logic [3:0]  ls_be_i;
  logic [31:0] ls_addr_i, ls_wdata_i;
  logic        ls_gnt_o, ls_rvalid_o, ls_err_o;
  logic [31:0] ls_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int n_checks = 0;
  int n_pass   = 0;

  mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i),
    .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i), .ls_lock_i(ls_lock_i),
    .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .ls_err_o(ls_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Called in the REQ cycle: accept immediately, respond the next cycle.
  task automatic serve(input bit own_ls, input logic [31:0] addr, input logic we,
                       input logic [3:0] be, input logic [31:0] wdata,
                       input logic [31:0] rdata);
    mem_gnt_i = 1'b1;
    #2;
    chk("req_active", mem_req_o, 1);
    chk("req_addr", mem_addr_o, addr);
    chk("req_we", mem_we_o, we);
    chk("req_be", mem_be_o, be);
    chk("req_wdata", mem_wdata_o, wdata);
    chk("busy_no_gnt", {if_gnt_o, ls_gnt_o}, 0);
    tick();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rdata;
    #2;
    chk("resp_req_low", mem_req_o, 0);
    chk("resp_valid", own_ls ? ls_rvalid_o : if_rvalid_o, 1);
    chk("resp_other", own_ls ? if_rvalid_o : ls_rvalid_o, 0);
    chk("resp_rdata", own_ls ? ls_rdata_o : if_rdata_o, rdata);
    chk("resp_err", own_ls ? ls_err_o : if_err_o, 0);
    tick();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
  endtask

  initial begin
    rst_i = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h100;
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_be_i = 4'hF; ls_addr_i = 32'h4000;
    ls_wdata_i = 32'h0; ls_lock_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    #3;
    chk("rst_gnt", {if_gnt_o, ls_gnt_o}, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_rvalid", {if_rvalid_o, ls_rvalid_o}, 0);
    tick();
    rst_i = 1'b1; if_req_i = 1'b0; ls_req_i = 1'b0;
    tick();

    // Single fetch with minimum latency; requester drops req after grant.
    if_req_i = 1'b1;
    #2;
    chk("f_gnt", if_gnt_o, 1);
    chk("f_ls_gnt", ls_gnt_o, 0);
    chk("f_mem_req_n", mem_req_o, 0);
    tick();
    if_req_i = 1'b0;
    serve(1'b0, 32'h100, 1'b0, 4'hF, 32'h0, 32'h13);
    #2;
    chk("f_rvalid_end", if_rvalid_o, 0);
    chk("f_rdata_zero", if_rdata_o, 0);

    // Round robin from a fresh reset: fetch, LSU, fetch, LSU.
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    if_req_i = 1'b1; ls_req_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("rr_if_gnt", if_gnt_o, (i % 2 == 0) ? 1 : 0);
      chk("rr_ls_gnt", ls_gnt_o, (i % 2 == 1) ? 1 : 0);
      tick();
      serve(i % 2 == 1, (i % 2 == 1) ? 32'h4000 : 32'h100, 1'b0, 4'hF, 32'h0,
            32'h1000 + 32'(i));
    end
    if_req_i = 1'b0; ls_req_i = 1'b0;

    // Lock: locked read, then unlocking write; fetch held off until write completes.
    ls_req_i = 1'b1; ls_lock_i = 1'b1; ls_addr_i = 32'h2000;
    #2;
    chk("lk_ls_gnt", ls_gnt_o, 1);
    tick();
    ls_req_i = 1'b0; if_req_i = 1'b1;
    serve(1'b1, 32'h2000, 1'b0, 4'hF, 32'h0, 32'h55);
    #2;
    chk("lk_block", if_gnt_o, 0);
    tick();
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_lock_i = 1'b0; ls_wdata_i = 32'hDEAD_BEEF;
    #2;
    chk("lk_wr_gnt", ls_gnt_o, 1);
    chk("lk_wr_if", if_gnt_o, 0);
    tick();
    ls_req_i = 1'b0; ls_we_i = 1'b0;
    serve(1'b1, 32'h2000, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0);
    #2;
    chk("lk_release", if_gnt_o, 1);
    tick();
    if_req_i = 1'b0;
    serve(1'b0, 32'h100, 1'b0, 4'hF, 32'h0, 32'h66);

    // Partial-word write.
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_be_i = 4'b0011;
    ls_addr_i = 32'h3004; ls_wdata_i = 32'h1234;
    #2;
    chk("wr_gnt", ls_gnt_o, 1);
    tick();
    ls_req_i = 1'b0; ls_we_i = 1'b0; ls_be_i = 4'hF;
    serve(1'b1, 32'h3004, 1'b1, 4'b0011, 32'h1234, 32'h0);

    // Timeout: no mem_gnt_i, error pulse in the ninth cycle after grant.
    ls_req_i = 1'b1; ls_addr_i = 32'h5000; ls_wdata_i = 32'h0;
    #2;
    chk("to_gnt", ls_gnt_o, 1);
    tick();
    ls_req_i = 1'b0; mem_rdata_i = 32'hFFFF_FFFF;
    for (int k = 0; k < 8; k++) begin
      #2;
      chk("to_wait_req", mem_req_o, 1);
      chk("to_wait_rv", ls_rvalid_o, 0);
      tick();
    end
    #2;
    chk("to_rvalid", ls_rvalid_o, 1);
    chk("to_err", ls_err_o, 1);
    chk("to_rdata", ls_rdata_o, 0);
    chk("to_req_low", mem_req_o, 0);
    tick();
    mem_rdata_i = 32'h0; if_req_i = 1'b1;
    #2;
    chk("to_after_rv", ls_rvalid_o, 0);
    chk("to_next_gnt", if_gnt_o, 1);
    tick();
    if_req_i = 1'b0;
    serve(1'b0, 32'h100, 1'b0, 4'hF, 32'h0, 32'h42);

    // Response arriving exactly at the timeout cycle wins.
    if_req_i = 1'b1;
    #2;
    chk("tr_gnt", if_gnt_o, 1);
    tick();
    if_req_i = 1'b0; mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    for (int k = 1; k < 8; k++) begin
      #2;
      chk("tr_wait_rv", if_rvalid_o, 0);
      tick();
    end
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77;
    #2;
    chk("tr_rvalid", if_rvalid_o, 1);
    chk("tr_err", if_err_o, 0);
    chk("tr_rdata", if_rdata_o, 32'h77);
    tick();
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;

    // Asynchronous reset during RESP; stale response afterwards is ignored.
    if_req_i = 1'b1;
    #2;
    chk("ar_gnt", if_gnt_o, 1);
    tick();
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h99;
    #2;
    chk("ar_pre_rv", if_rvalid_o, 1);
    rst_i = 1'b0;
    #1;
    chk("ar_rv", if_rvalid_o, 0);
    chk("ar_rdata", if_rdata_o, 0);
    chk("ar_gnt_rst", if_gnt_o, 0);
    chk("ar_mem_req", mem_req_o, 0);
    tick();
    rst_i = 1'b1; if_req_i = 1'b0;
    #2;
    chk("ar_stale_rv", {if_rvalid_o, ls_rvalid_o}, 0);
    tick();
    #2;
    chk("ar_stale_rv2", {if_rvalid_o, ls_rvalid_o}, 0);
    chk("ar_mem_req2", mem_req_o, 0);
    mem_rvalid_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
